except_ctrl: RTL

Exception/interrupt arbiter that drives the CP0 register block's exception inputs and redirects the pipeline. It sits beside the MEM stage. Each cycle it:
- reads bypassed Status/Cause/EPC;
- picks the highest-priority exception for the instruction in MEM and reports it to CP0;
- stalls, flushes and redirects the front end through a small state machine.

---
 rtl/except_ctrl_pkg.sv | 52 +++++
 rtl/except_ctrl_cp0_bypass.sv | 44 ++++
 rtl/except_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/except_ctrl_pkg.sv
// Shared constants for the exception controller: exception codes, CP0
// register addresses, reset polarity, vector address and FSM state encoding.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0020;
  localparam int          DRAIN_CYCLES = 2;
  localparam int          DRAIN_W      = 3;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [4:0]  CP0_REG_STATUS = 5'd12;
  localparam logic [4:0]  CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_REG_EPC    = 5'd14;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Fixed-priority pick of the exception code; interrupt already folds in valid.
  function automatic logic [31:0] pick_code(
    input logic int_pend,
    input logic valid,
    input logic syscall,
    input logic ri,
    input logic trap,
    input logic ov,
    input logic eret
  );
    logic [31:0] code;
    code = EXC_NONE;
    if (int_pend)             code = EXC_INT;
    else if (valid && syscall) code = EXC_SYSCALL;
    else if (valid && ri)      code = EXC_RI;
    else if (valid && trap)    code = EXC_TRAP;
    else if (valid && ov)      code = EXC_OV;
    else if (valid && eret)    code = EXC_ERET;
    else                       code = EXC_NONE;
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_cp0_bypass.sv
// Forwards an in-flight WB mtc0 write onto the Status/Cause/EPC values seen
// by the exception arbiter, so a write in WB is visible in the same cycle.
module except_ctrl_cp0_bypass
  import except_ctrl_pkg::*;
(
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  // Select register value or WB data; Cause only takes its software-writable bits.
  always_comb begin
    status = cp0_status_i;
    cause  = cp0_cause_i;
    epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_REG_STATUS: status = wb_cp0_wdata_i;
        CP0_REG_EPC:    epc    = wb_cp0_wdata_i;
        CP0_REG_CAUSE: begin
          cause[9:8] = wb_cp0_wdata_i[9:8];
          cause[22]  = wb_cp0_wdata_i[22];
          cause[23]  = wb_cp0_wdata_i[23];
        end
        default: begin
          status = cp0_status_i;
          cause  = cp0_cause_i;
          epc    = cp0_epc_i;
        end
      endcase
    end else begin
      status = cp0_status_i;
      cause  = cp0_cause_i;
      epc    = cp0_epc_i;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt arbiter beside MEM: reports the winning exception to
// CP0 combinationally, then stalls, flushes and redirects via a RUN/FLUSH/
// DRAIN state machine. Optional taken-exception counter: define EXC_COUNT_EN.
module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_syscall_i,
  input  logic        mem_ri_i,
  input  logic        mem_trap_i,
  input  logic        mem_ov_i,
  input  logic        mem_eret_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] exc_count_o
);

  logic [31:0]        status;
  logic [31:0]        cause;
  logic [31:0]        epc;
  logic               int_pend;
  logic [31:0]        code;
  logic               exc_take;
  state_e             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               unused_bits;

  except_ctrl_cp0_bypass u_bypass (
    .cp0_status_i   (cp0_status_i),
    .cp0_cause_i    (cp0_cause_i),
    .cp0_epc_i      (cp0_epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_wdata_i (wb_cp0_wdata_i),
    .status         (status),
    .cause          (cause),
    .epc            (epc)
  );

  assign unused_bits = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};

  // Arbitrate and drive the CP0 exception inputs; only RUN may report, reset suppresses.
  always_comb begin
    int_pend = mem_valid_i && ((cause[15:8] & status[15:8]) != 8'h00)
               && status[0] && !status[1];
    code     = pick_code(int_pend, mem_valid_i, mem_syscall_i, mem_ri_i,
                         mem_trap_i, mem_ov_i, mem_eret_i);
    exc_take = (state == ST_RUN) && (rst != RST_ENABLE) && (code != EXC_NONE);
    if (exc_take) begin
      excepttype_o        = code;
      current_inst_addr_o = mem_inst_addr_i;
      is_in_delayslot_o   = mem_in_delayslot_i;
      stall_o             = 1'b1;
    end else begin
      excepttype_o        = ZERO_WORD;
      current_inst_addr_o = ZERO_WORD;
      is_in_delayslot_o   = 1'b0;
      stall_o             = 1'b0;
    end
  end

  // Control FSM: capture redirect target on detection, flush one cycle, then drain.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      flush_o   <= 1'b0;
      new_pc_o  <= ZERO_WORD;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_take) begin
            state    <= ST_FLUSH;
            flush_o  <= 1'b1;
            new_pc_o <= (code == EXC_ERET) ? epc : EXC_VECTOR;
          end else begin
            state   <= ST_RUN;
            flush_o <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state     <= ST_DRAIN;
          flush_o   <= 1'b0;
          drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
        end
        ST_DRAIN: begin
          flush_o <= 1'b0;
          if (drain_cnt <= DRAIN_W'(1)) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
          end else begin
            state     <= ST_DRAIN;
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_o   <= 1'b0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic [31:0] exc_count;

  // Count taken exceptions (eret is a return, not an exception); wraps naturally.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      exc_count <= ZERO_WORD;
    end else if (exc_take && (code != EXC_ERET)) begin
      exc_count <= exc_count + 32'd1;
    end else begin
      exc_count <= exc_count;
    end
  end

  assign exc_count_o = exc_count;
`else
  assign exc_count_o = ZERO_WORD;
`endif

endmodule
